// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 serial driver: FSM encoding and parameter defaults.
package hc595_pkg;

  localparam int unsigned DefaultDiv   = 4;
  localparam int unsigned DefaultNbits = 8;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StShiftLo,
    StShiftHi,
    StLatch
  } state_e;

endpackage

// File: rtl/hc595_tick.sv
// Restartable DIV-cycle phase timer; tick marks the last cycle of the current phase.
module hc595_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] Last = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart || (cnt_q == Last)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == Last);

endmodule

// File: rtl/hc595_driver.sv
// Serialises a parallel word into one or more cascaded 74HC595 shift registers,
// then pulses the storage latch; also handles shift-register clear and output enable.
module hc595_driver
  import hc595_pkg::*;
#(
  parameter int unsigned DIV   = DefaultDiv,
  parameter int unsigned NBITS = DefaultNbits
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  input  logic             oe_en,
  output logic             done,
  output logic             SER,
  output logic             SRCLK,
  output logic             RCLK,
  output logic             SRCLR_n,
  output logic             OE_n
);

  localparam int unsigned BcW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [BcW-1:0] LastBit = BcW'(NBITS - 1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic [BcW-1:0]   bit_q, bit_d;
  logic             pend_q, pend_d;
  logic             ser_q, ser_d;
  logic             done_d;
  logic             srclk_q, rclk_q, srclr_n_q, oe_n_q, done_q, ready_q;
  logic             tick, restart;

  // Timer restarts on every state entry and is held at zero while idle.
  assign restart = (state_d != state_q) || (state_q == StIdle);

  hc595_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    pend_d  = pend_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    if (clr && (state_q != StIdle)) begin
      pend_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        // A requested clear always runs before the next word is accepted.
        if (clr || pend_q) begin
          state_d = StClear;
          pend_d  = 1'b0;
        end else if (in_valid && ready_q) begin
          state_d = StShiftLo;
          sr_d    = in_data;
          ser_d   = in_data[NBITS-1];
          bit_d   = '0;
        end
      end
      StClear: begin
        if (tick) state_d = StIdle;
      end
      StShiftLo: begin
        if (tick) state_d = StShiftHi;
      end
      StShiftHi: begin
        if (tick) begin
          if (bit_q == LastBit) begin
            state_d = StLatch;
          end else begin
            state_d = StShiftLo;
            sr_d    = {sr_q[NBITS-2:0], 1'b0};
            ser_d   = sr_q[NBITS-2];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      StLatch: begin
        if (tick) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_q     <= '0;
      pend_q    <= 1'b0;
      ser_q     <= 1'b0;
      srclk_q   <= 1'b0;
      rclk_q    <= 1'b0;
      srclr_n_q <= 1'b0;
      oe_n_q    <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_q     <= bit_d;
      pend_q    <= pend_d;
      ser_q     <= ser_d;
      srclk_q   <= (state_d == StShiftHi);
      rclk_q    <= (state_d == StLatch);
      srclr_n_q <= (state_d != StClear);
      oe_n_q    <= ~oe_en;
      done_q    <= done_d;
      ready_q   <= (state_d == StIdle) && !pend_d;
    end
  end

  assign SER      = ser_q;
  assign SRCLK    = srclk_q;
  assign RCLK     = rclk_q;
  assign SRCLR_n  = srclr_n_q;
  assign OE_n     = oe_n_q;
  assign done     = done_q;
  assign in_ready = ready_q;

endmodule

// File: tb/tb_hc595_driver.sv
// Directed bench for hc595_driver: 8-bit/DIV=4 instance plus a 16-bit/DIV=2 cascade,
// each observed through a behavioural 74HC595 model.
module tb_hc595_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, clr, oe_en;
  logic       in_ready, done, SER, SRCLK, RCLK, SRCLR_n, OE_n;

  logic [15:0] in_data_b;
  logic        in_valid_b;
  logic        clr_b = 1'b0;
  logic        oe_en_b = 1'b0;
  logic        in_ready_b, done_b, ser_b, srclk_b, rclk_b, srclr_n_b, oe_n_b;

  hc595_driver #(
    .DIV  (4),
    .NBITS(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .clr     (clr),
    .oe_en   (oe_en),
    .done    (done),
    .SER     (SER),
    .SRCLK   (SRCLK),
    .RCLK    (RCLK),
    .SRCLR_n (SRCLR_n),
    .OE_n    (OE_n)
  );

  hc595_driver #(
    .DIV  (2),
    .NBITS(16)
  ) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data_b),
    .in_valid(in_valid_b),
    .in_ready(in_ready_b),
    .clr     (clr_b),
    .oe_en   (oe_en_b),
    .done    (done_b),
    .SER     (ser_b),
    .SRCLK   (srclk_b),
    .RCLK    (rclk_b),
    .SRCLR_n (srclr_n_b),
    .OE_n    (oe_n_b)
  );

  // 74HC595 models: shift on SRCLK rise, async clear, storage latch on RCLK rise.
  logic [7:0]  m_sr = '0;
  logic [7:0]  m_q = '0;
  logic [15:0] mb_sr = '0;
  logic [15:0] mb_q = '0;

  always @(posedge SRCLK or negedge SRCLR_n)
    if (!SRCLR_n) m_sr <= '0;
    else          m_sr <= {m_sr[6:0], SER};
  always @(posedge RCLK) m_q <= m_sr;

  always @(posedge srclk_b or negedge srclr_n_b)
    if (!srclr_n_b) mb_sr <= '0;
    else            mb_sr <= {mb_sr[14:0], ser_b};
  always @(posedge rclk_b) mb_q <= mb_sr;

  int   srclk_rises = 0, rclk_rises = 0, ser_viol = 0, srclk_rises_b = 0;
  logic srclk_prev = 1'b0, rclk_prev = 1'b0, ser_prev = 1'b0, srclk_b_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (SRCLK && !srclk_prev) begin
      srclk_rises++;
      if (SER !== ser_prev) ser_viol++;
    end
    if (RCLK && !rclk_prev) rclk_rises++;
    if (srclk_b && !srclk_b_prev) srclk_rises_b++;
    srclk_prev   = SRCLK;
    rclk_prev    = RCLK;
    ser_prev     = SER;
    srclk_b_prev = srclk_b;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for a single edge; caller guarantees in_ready at that edge.
  task automatic send(input logic [7:0] w);
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int r0, q0, v0, lows;
    int bad_srclk, bad_rclk, bad_done, bad_rdy, bad_oe;

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; clr = 1'b0; oe_en = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0;

    // Reset values
    #12;
    check_eq("rst_ser",     SER,      1'b0);
    check_eq("rst_srclk",   SRCLK,    1'b0);
    check_eq("rst_rclk",    RCLK,     1'b0);
    check_eq("rst_srclr_n", SRCLR_n,  1'b0);
    check_eq("rst_oe_n",    OE_n,     1'b1);
    check_eq("rst_done",    done,     1'b0);
    check_eq("rst_ready",   in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_srclr_n", SRCLR_n,    1'b1);
    check_eq("post_rst_ready",   in_ready,   1'b1);
    check_eq("post_rst_ready_b", in_ready_b, 1'b1);

    // Single frame 0xA5 with cycle-exact waveform, mid-frame noise and OE toggling
    r0 = srclk_rises; q0 = rclk_rises; v0 = ser_viol;
    bad_srclk = 0; bad_rclk = 0; bad_done = 0; bad_rdy = 0; bad_oe = 0;
    send(8'hA5);
    for (int k = 0; k <= 70; k++) begin
      if (SRCLK !== (k < 64 && ((k / 4) % 2 == 1))) bad_srclk++;
      if (RCLK !== (k >= 64 && k <= 67)) bad_rclk++;
      if (done !== (k == 68)) bad_done++;
      if (in_ready !== (k >= 68)) bad_rdy++;
      if (OE_n !== (k <= 10 || k >= 31)) bad_oe++;
      if (k == 5) begin in_data = 8'h3C; in_valid = 1'b1; end
      if (k == 20) in_valid = 1'b0;
      if (k == 10) oe_en = 1'b1;
      if (k == 30) oe_en = 1'b0;
      if (k < 70) step();
    end
    check_eq("a5_srclk_wave",  bad_srclk, 0);
    check_eq("a5_rclk_window", bad_rclk,  0);
    check_eq("a5_done_pulse",  bad_done,  0);
    check_eq("a5_ready_lat",   bad_rdy,   0);
    check_eq("a5_oe_follow",   bad_oe,    0);
    check_eq("a5_srclk_rises", srclk_rises - r0, 8);
    check_eq("a5_rclk_rises",  rclk_rises - q0,  1);
    check_eq("a5_ser_stable",  ser_viol - v0,    0);
    check_eq("a5_model_q",     m_q, 8'hA5);

    // Back-to-back 0x01 then 0x80 with in_valid held
    @(negedge clk);
    in_data = 8'h01; in_valid = 1'b1;
    step();
    in_data = 8'h80;
    repeat (68) step();
    check_eq("b2b_ready_68", in_ready, 1'b1);
    check_eq("b2b_done_68",  done,     1'b1);
    check_eq("b2b_q_first",  m_q,      8'h01);
    step();
    check_eq("b2b_ready_69", in_ready, 1'b0);
    check_eq("b2b_ser_69",   SER,      1'b1);
    in_valid = 1'b0;
    repeat (68) step();
    check_eq("b2b_done_2",   done,     1'b1);
    check_eq("b2b_q_second", m_q,      8'h80);

    // clr mid-frame: frame completes, one deferred clear of DIV cycles
    send(8'hC3);
    repeat (10) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (9) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (47) step();
    check_eq("clr_done_68",    done,     1'b1);
    check_eq("clr_ready_68",   in_ready, 1'b0);
    check_eq("clr_srclr_n_68", SRCLR_n,  1'b1);
    check_eq("clr_q",          m_q,      8'hC3);
    lows = 0;
    for (int k = 69; k <= 80; k++) begin
      step();
      if (!SRCLR_n) lows++;
      if (k == 72) check_eq("clr_ready_72", in_ready, 1'b0);
      if (k == 73) check_eq("clr_ready_73", in_ready, 1'b1);
    end
    check_eq("clr_low_cycles", lows, 4);
    check_eq("clr_model_sr",   m_sr, 8'h00);
    check_eq("clr_q_kept",     m_q,  8'hC3);

    // clr in IDLE beats a simultaneous in_valid
    r0 = srclk_rises;
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    step();
    clr = 1'b0; in_valid = 1'b0;
    check_eq("idle_clr_srclr_n_0", SRCLR_n,  1'b0);
    check_eq("idle_clr_ready_0",   in_ready, 1'b0);
    repeat (3) step();
    check_eq("idle_clr_srclr_n_3", SRCLR_n,  1'b0);
    step();
    check_eq("idle_clr_srclr_n_4", SRCLR_n,  1'b1);
    check_eq("idle_clr_ready_4",   in_ready, 1'b1);
    check_eq("idle_clr_no_shift",  srclk_rises - r0, 0);

    // Reset 30 cycles into a frame
    @(negedge clk);
    oe_en = 1'b1;
    q0 = rclk_rises;
    send(8'hA5);
    repeat (30) step();
    check_eq("rst30_srclk_pre", SRCLK, 1'b1);
    check_eq("rst30_oe_n_pre",  OE_n,  1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("rst30_srclr_n", SRCLR_n,  1'b0);
    check_eq("rst30_oe_n",    OE_n,     1'b1);
    check_eq("rst30_srclk",   SRCLK,    1'b0);
    check_eq("rst30_rclk",    RCLK,     1'b0);
    check_eq("rst30_ready",   in_ready, 1'b0);
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("rst30_ready_rel",   in_ready, 1'b1);
    check_eq("rst30_srclr_n_rel", SRCLR_n,  1'b1);
    check_eq("rst30_oe_n_rel",    OE_n,     1'b0);
    repeat (40) step();
    check_eq("rst30_no_rclk", rclk_rises - q0, 0);
    check_eq("rst30_no_done", done, 1'b0);
    oe_en = 1'b0;

    // 16-bit cascade, DIV=2
    r0 = srclk_rises_b;
    @(negedge clk);
    in_data_b = 16'hBEEF; in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    repeat (65) step();
    check_eq("b16_ready_65", in_ready_b, 1'b0);
    check_eq("b16_done_65",  done_b,     1'b0);
    step();
    check_eq("b16_ready_66", in_ready_b, 1'b1);
    check_eq("b16_done_66",  done_b,     1'b1);
    check_eq("b16_upper",    mb_q[15:8], 8'hBE);
    check_eq("b16_lower",    mb_q[7:0],  8'hEF);
    check_eq("b16_srclk_rises", srclk_rises_b - r0, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
